// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder: select {a,b,c} (a = MSB) drives exactly one of d0..d7.
// Latency: 1 clk from the sampling edge to the outputs; one new select accepted every cycle.
// Backpressure: none; there is no handshake, and valid qualifies the outputs after reset.
module decoder_3to8 (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic d4,
    output logic d5,
    output logic d6,
    output logic d7,
    output logic valid
);

    logic [2:0] sel;
    logic [7:0] dec_q;
    logic       valid_q;

    assign sel = {a, b, c};

    // Decode ahead of the flops so every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= 8'h01 << sel;
            valid_q <= 1'b1;
        end
    end

    assign d0    = dec_q[0];
    assign d1    = dec_q[1];
    assign d2    = dec_q[2];
    assign d3    = dec_q[3];
    assign d4    = dec_q[4];
    assign d5    = dec_q[5];
    assign d6    = dec_q[6];
    assign d7    = dec_q[7];
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed and random stimulus for decoder_3to8, checked against a sampled-index model.
module tb_decoder_3to8;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c;
    logic d0, d1, d2, d3, d4, d5, d6, d7, valid;
    logic [7:0] dvec;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = -1;   // index captured at the last edge, -1 while in reset
    logic [7:0] exp_vec;

    decoder_3to8 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .valid(valid)
    );

    always #5 clk = ~clk;

    assign dvec = {d7, d6, d5, d4, d3, d2, d1, d0};

    always @(posedge clk) if (rst_n === 1'b1) exp_idx = int'({a, b, c});
    always @(negedge rst_n) exp_idx = -1;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_vec = 8'h00;
        if (exp_idx >= 0) exp_vec[exp_idx] = 1'b1;
        check("model_lines", {1'b0, dvec}, {1'b0, exp_vec});
        check("model_valid", {8'h00, valid}, {8'h00, exp_idx >= 0});
        if (valid === 1'b1)
            check("onehot", {1'b0, 8'($countones(dvec))}, 9'd1);
    end

    task automatic set_sel(input logic [2:0] s);
        {a, b, c} = s;
    endtask

    logic [7:0] sweep_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        rst_n = 1'b0;
        set_sel(3'b111);
        repeat (4) @(negedge clk);
        check("reset_hold", {dvec, valid}, 9'h000);

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_sel(3'(i));
            @(posedge clk); #1;
            check("sweep", {dvec, valid}, {sweep_tbl[i], 1'b1});
            @(negedge clk);
        end

        // Mid-cycle select change must not reach the outputs before the next edge.
        set_sel(3'b010);
        @(posedge clk); #1;
        check("glitch_pre", {dvec, valid}, 9'b00000100_1);
        #1 set_sel(3'b110);
        #1 check("glitch_hold", {dvec, valid}, 9'b00000100_1);
        @(posedge clk); #1;
        check("glitch_post", {dvec, valid}, 9'b01000000_1);
        @(negedge clk);

        set_sel(3'b111);
        @(posedge clk); #1;
        check("wrap_7", {dvec, valid}, 9'b10000000_1);
        @(negedge clk);
        set_sel(3'b000);
        @(posedge clk); #1;
        check("wrap_0", {dvec, valid}, 9'b00000001_1);
        @(negedge clk);

        set_sel(3'b100);
        @(posedge clk); #1;
        check("pre_arst_d4", {dvec, valid}, 9'b00010000_1);
        #2 rst_n = 1'b0;
        #1 check("arst_async", {dvec, valid}, 9'h000);
        @(negedge clk);
        set_sel(3'b011);
        @(posedge clk); #1;
        check("arst_held", {dvec, valid}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_release", {dvec, valid}, 9'b00001000_1);
        @(negedge clk);

        set_sel(3'b011);
        @(posedge clk); #1;
        check("repeat_sel", {dvec, valid}, 9'b00001000_1);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            set_sel(3'($urandom_range(7, 0)));
            @(negedge clk);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_3to8.md
# decoder_3to8

Registered 3-to-8 line decoder. It converts a 3-bit binary select, presented on three single-bit inputs, into eight one-hot output lines. It serves as a generic select/enable fan-out block wherever a binary-encoded index must drive individual strobe lines. Outputs are registered on a single clock and cleared by an asynchronous active-low reset.

## Interface
- Parameters: none.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `a`  input  1  select bit 2 (MSB).
- `b`  input  1  select bit 1.
- `c`  input  1  select bit 0 (LSB).
- `d0`..`d7`  output  1 each  decoded lines; `dN` is high when the sampled select equals N.
- `valid`  output  1  high once the outputs hold a decoded value; low during and after reset until the first capture.
- Port order: `clk`, `rst_n`, `a`, `b`, `c`, `d0`..`d7`, `valid`.

## Operation
- Select index: sel = {a, b, c}, giving an unsigned value 0..7 with `a` as MSB.
- On each rising `clk` edge with `rst_n` high:
  - register sel;
  - set `dN` = 1 for N == sel, and all other `dM` = 0;
  - set `valid` = 1.
- Output encoding is active-high one-hot. Exactly one of `d0`..`d7` is high whenever `valid` = 1.
- All eight sel values are legal; there are no don't-care or invalid codes.
- Inputs are sampled only at the clock edge. Changes between edges have no effect on the outputs.
- Outputs are driven directly from flops, with no combinational path from the inputs to the outputs.

## Timing
- Latency: 1 clock. A select value present at rising edge k appears on `d0`..`d7` after edge k and holds until edge k+1.
- Throughput: one new select value per clock, with no stall and no handshake.
- Reset, when `rst_n` goes low:
  - `d0`..`d7` and `valid` go to 0 immediately, independent of `clk`;
  - the outputs are all-zero, which is not one-hot; consumers qualify with `valid`.
- Reset release: deassertion should be synchronized externally to `clk`. The first rising edge with `rst_n` high captures sel, asserts the matching `dN`, and sets `valid` = 1.
- Reset mid-operation clears all outputs asynchronously, regardless of the current sel or clock phase.
- Wrap-around: sel changing from 7 to 0 moves the active line from `d7` to `d0` in one clock. No intermediate state is visible at the outputs.
- Back-to-back identical sel values leave the outputs unchanged.

## Test plan
- Reset check: hold `rst_n` = 0 with a,b,c = 1,1,1 and clock running. Required: `d0`..`d7` = 0 and `valid` = 0 on every cycle.
- Exhaustive sweep: after reset, apply a,b,c = 000, 001, …, 111, one value per clock.
  - One edge after each value, exactly `dN` (N = 0..7) is high, the other seven are low, and `valid` = 1.
  - Example: 101 drives `d5` = 1.
- Latency and glitch: change a,b,c from 010 to 110 mid-cycle.
  - `d2` stays high until the next rising edge, then `d6` = 1 and `d2` = 0.
  - The outputs do not change between edges.
- Wrap: step sel 111 → 000 on consecutive clocks. Required: `d7` = 1 then `d0` = 1, never both and never neither, with `valid` = 1.
- Asynchronous reset mid-run: while `d4` = 1, pull `rst_n` low between clock edges.
  - All outputs and `valid` drop to 0 before the next edge.
  - After release, the first edge with sel = 011 gives `d3` = 1 and `valid` = 1.
- One-hot property: random a,b,c for 1000 cycles. Whenever `valid` = 1, exactly one output is high, and it matches the sel sampled one clock earlier.
